// File: rtl/ppu_update_scheduler_if.sv
// Avalon slave bus between the CPU bridge and the sprite update scheduler.
// No logic here, so no latency of its own; readdata is driven by the slave one cycle after a read.
// Backpressure: none; the Avalon slave never stalls (waitrequest is not used).
// Ports: chipselect/write/read strobes, 3-bit word address, 32-bit writedata and readdata.
interface ppu_update_scheduler_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/ppu_update_scheduler.sv
// Command FIFO with occupancy count; a push into a full FIFO is taken only when a pop frees a slot.
// Latency: rd_dat always shows the head entry; a pushed entry is poppable on the next cycle.
// Backpressure: push_acc low means the entry was dropped; pop into an empty FIFO is ignored.
// Ports: clk/reset, push/wr_dat, pop/rd_dat, level (0..DEPTH), full, empty, push_acc.
module ppu_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     push_acc
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign pop_ok   = pop && !empty;
    assign push_acc = push && (!full || pop_ok);
    assign rd_dat   = mem[rd_ptr];

    // Storage needs no reset: level gates every read of it.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)   rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// Queues CPU sprite-register writes and replays them to the sprite display slots in vertical blank.
// Latency: entry popped in cycle N strobes obj_we/obj_data in N+1; first pop is 1 cycle after vblank_start.
// Backpressure: none to the CPU; a write into a full queue is dropped and raises the overflow flag.
// Ports: clk, reset, bus (Avalon slave: addr 0 = command/status, addr 1 = clear flags),
//        hcount/vcount (VGA timing), obj_we (one-hot strobe), obj_data, frame_start (pulse).
module ppu_update_scheduler #(
    parameter int NUM_OBJ     = 20,
    parameter int FIFO_DEPTH  = 16,
    parameter int VBLANK_LINE = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    ppu_update_scheduler_if.slave  bus,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    output logic [NUM_OBJ-1:0]     obj_we,
    output logic [31:0]            obj_data,
    output logic                   frame_start
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic               push_req;
    logic               clr_req;
    logic               rd_req;
    logic               vblank_start;
    logic               blank_end;
    logic               pop;
    logic               push_acc;
    logic               full;
    logic               empty;
    logic [LW-1:0]      level;
    logic [31:0]        head_dat;
    logic [4:0]         head_id;
    logic               bad_pop;
    logic [NUM_OBJ-1:0] we_next;
    logic               overflow;
    logic               bad_id;
    logic [15:0]        frame_count;
    logic [31:0]        status;

    assign push_req     = bus.chipselect && bus.write && (bus.address == 3'd0);
    assign clr_req      = bus.chipselect && bus.write && (bus.address == 3'd1);
    assign rd_req       = bus.chipselect && bus.read  && (bus.address == 3'd0);
    assign vblank_start = (vcount == 10'(VBLANK_LINE)) && (hcount == 10'd0);
    assign blank_end    = (vcount == 10'd0);

    // No pop on the line where blank ends, so the IDLE hand-off loses nothing.
    assign pop = (state == DRAIN) && !empty && !blank_end;

    ppu_cmd_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_req),
        .wr_dat   (bus.writedata),
        .pop      (pop),
        .rd_dat   (head_dat),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .push_acc (push_acc)
    );

    assign head_id = head_dat[31:27];
    assign bad_pop = pop && (int'(head_id) >= NUM_OBJ);

    always_comb begin
        we_next = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            we_next[i] = pop && (int'(head_id) == i);
        end
    end

    always_comb begin
        status        = '0;
        status[7:0]   = 8'(level);
        status[8]     = overflow;
        status[9]     = bad_id;
        status[10]    = (state == DRAIN);
        status[31:16] = frame_count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            obj_we      <= '0;
            obj_data    <= '0;
            frame_start <= 1'b0;
            frame_count <= '0;
            overflow    <= 1'b0;
            bad_id      <= 1'b0;
            bus.readdata <= '0;
        end else begin
            case (state)
                IDLE:    if (vblank_start) state <= DRAIN;
                // A push landing on an empty cycle keeps us draining.
                DRAIN:   if (blank_end) state <= IDLE;
                         else if (empty && !push_acc) state <= DONE;
                DONE:    if (blank_end) state <= IDLE;
                default: state <= IDLE;
            endcase

            obj_we <= we_next;
            if (pop && !bad_pop) begin
                obj_data <= head_dat;
            end

            frame_start <= vblank_start;
            if (vblank_start) begin
                frame_count <= frame_count + 16'd1;
            end

            if (clr_req) begin
                overflow <= 1'b0;
            end else if (push_req && !push_acc) begin
                overflow <= 1'b1;
            end

            // A bad entry popped in the same cycle as a clear still shows up.
            if (bad_pop) begin
                bad_id <= 1'b1;
            end else if (clr_req) begin
                bad_id <= 1'b0;
            end

            bus.readdata <= rd_req ? status : 32'd0;
        end
    end
endmodule

// File: tb/tb_ppu_update_scheduler.sv
module tb_ppu_update_scheduler;
    localparam int NUM_OBJ     = 20;
    localparam int FIFO_DEPTH  = 16;
    localparam int VBLANK_LINE = 480;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         hcount;
    logic [9:0]         vcount;
    logic [NUM_OBJ-1:0] obj_we;
    logic [31:0]        obj_data;
    logic               frame_start;

    int checks = 0;
    int errors = 0;
    int fc_exp = 0;

    logic [NUM_OBJ-1:0] we_q[$];
    logic [31:0]        dat_q[$];

    ppu_update_scheduler_if bus ();

    ppu_update_scheduler #(
        .NUM_OBJ     (NUM_OBJ),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .VBLANK_LINE (VBLANK_LINE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .hcount      (hcount),
        .vcount      (vcount),
        .obj_we      (obj_we),
        .obj_data    (obj_data),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Records every strobe seen, 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (obj_we != '0) begin
            we_q.push_back(obj_we);
            dat_q.push_back(obj_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int id);
        logic [4:0] i5;
        i5 = 5'(id);
        return {i5, 27'(id) + 27'h00A5000};
    endfunction

    function automatic logic [31:0] st(input int lvl, input logic ovf, input logic bad,
                                       input logic drn, input int fc);
        logic [15:0] f;
        logic [7:0]  l;
        f = 16'(fc);
        l = 8'(lvl);
        return {f, 5'b0, drn, bad, ovf, l};
    endfunction

    function automatic logic [31:0] onehot(input int id);
        logic [31:0] one;
        one = 32'd1;
        return one << id;
    endfunction

    task automatic av_write(input logic [2:0] addr, input logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic av_read(input logic [2:0] addr, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        tick();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        d = bus.readdata;
    endtask

    task automatic push(input int id);
        av_write(3'd0, mk(id));
    endtask

    task automatic vblank();
        vcount = 10'(VBLANK_LINE);
        hcount = 10'd0;
        tick();
        hcount = 10'd1;
        fc_exp++;
    endtask

    task automatic end_blank();
        vcount = 10'd0;
        tick();
        vcount = 10'd100;
        hcount = 10'd5;
        tick();
    endtask

    task automatic check_q(input string tag, input int ids[$]);
        chk({tag, "_count"}, 32'(we_q.size()), 32'(ids.size()));
        for (int i = 0; i < ids.size(); i++) begin
            if (i < we_q.size()) begin
                chk({tag, "_we"}, 32'(we_q[i]), onehot(ids[i]));
                chk({tag, "_data"}, dat_q[i], mk(ids[i]));
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int ids[$];

        reset          = 1'b1;
        hcount         = 10'd5;
        vcount         = 10'd100;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_obj_we", 32'(obj_we), 32'd0);
        chk("rst_obj_data", obj_data, 32'd0);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("rst_readdata", bus.readdata, 32'd0);
        av_read(3'd0, rd);
        chk("rst_status", rd, st(0, 0, 0, 0, 0));

        // Three commands held until vblank, replayed on consecutive cycles
        we_q.delete(); dat_q.delete();
        push(3); push(7); push(14);
        av_read(3'd0, rd);
        chk("t1_level", rd, st(3, 0, 0, 0, 0));
        repeat (4) tick();
        hcount = 10'd0;
        tick();
        chk("t1_no_early", 32'(we_q.size()), 32'd0);
        vblank();
        chk("t1_frame_start", {31'd0, frame_start}, 32'd1);
        chk("t1_we_v1", 32'(obj_we), 32'd0);
        tick();
        chk("t1_frame_start_end", {31'd0, frame_start}, 32'd0);
        chk("t1_we3", 32'(obj_we), onehot(3));
        chk("t1_data3", obj_data, mk(3));
        tick();
        chk("t1_we7", 32'(obj_we), onehot(7));
        tick();
        chk("t1_we14", 32'(obj_we), onehot(14));
        chk("t1_data14", obj_data, mk(14));
        tick();
        chk("t1_we_off", 32'(obj_we), 32'd0);
        chk("t1_data_hold", obj_data, mk(14));
        tick();
        av_read(3'd0, rd);
        chk("t1_done_status", rd, st(0, 0, 0, 0, fc_exp));
        av_read(3'd2, rd);
        chk("t1_other_addr", rd, 32'd0);
        end_blank();

        // Overflow on 17th push, clear via address 1
        for (int k = 0; k < 17; k++) push(k);
        av_read(3'd0, rd);
        chk("t2_overflow", rd, st(16, 1, 0, 0, fc_exp));
        av_write(3'd1, 32'hFFFF_FFFF);
        av_read(3'd0, rd);
        chk("t2_cleared", rd, st(16, 0, 0, 0, fc_exp));

        // Push while full on the cycle of the first pop is accepted
        we_q.delete(); dat_q.delete();
        vblank();
        push(19);
        av_read(3'd0, rd);
        chk("t2_push_pop_full", rd, st(16, 0, 0, 1, fc_exp));
        repeat (20) tick();
        ids.delete();
        for (int k = 0; k < 16; k++) ids.push_back(k);
        ids.push_back(19);
        check_q("t2_replay", ids);
        av_read(3'd0, rd);
        chk("t2_drained", rd, st(0, 0, 0, 0, fc_exp));
        end_blank();

        // Out-of-range object ID
        we_q.delete(); dat_q.delete();
        push(25);
        vblank();
        repeat (5) tick();
        chk("t3_no_strobe", 32'(we_q.size()), 32'd0);
        av_read(3'd0, rd);
        chk("t3_bad_id", rd, st(0, 0, 1, 0, fc_exp));
        av_write(3'd1, 32'd0);
        av_read(3'd0, rd);
        chk("t3_bad_clear", rd, st(0, 0, 0, 0, fc_exp));
        end_blank();

        // Blank ends after five pops; the rest waits for the next frame
        for (int k = 0; k < 16; k++) push(k);
        we_q.delete(); dat_q.delete();
        vblank();
        repeat (4) tick();
        vcount = 10'd524;
        tick();
        vcount = 10'd0;
        tick();
        av_read(3'd0, rd);
        chk("t4_partial", rd, st(11, 0, 0, 0, fc_exp));
        ids.delete();
        for (int k = 0; k < 5; k++) ids.push_back(k);
        check_q("t4_first", ids);
        vcount = 10'd100;
        tick();
        we_q.delete(); dat_q.delete();
        vblank();
        repeat (15) tick();
        ids.delete();
        for (int k = 5; k < 16; k++) ids.push_back(k);
        check_q("t4_second", ids);
        av_read(3'd0, rd);
        chk("t4_empty", rd, st(0, 0, 0, 0, fc_exp));
        end_blank();

        // Reset in the middle of a drain
        for (int k = 0; k < 9; k++) push(k);
        vblank();
        tick();
        chk("t5_we_before", 32'(obj_we), onehot(0));
        #2;
        reset = 1'b1;
        #1;
        chk("t5_we_reset", 32'(obj_we), 32'd0);
        chk("t5_data_reset", obj_data, 32'd0);
        #2;
        reset = 1'b0;
        fc_exp = 0;
        tick();
        av_read(3'd0, rd);
        chk("t5_status", rd, st(0, 0, 0, 0, 0));
        we_q.delete(); dat_q.delete();
        vblank();
        repeat (5) tick();
        chk("t5_nothing_left", 32'(we_q.size()), 32'd0);
        av_read(3'd0, rd);
        chk("t5_fc_restart", rd, st(0, 0, 0, 0, fc_exp));
        end_blank();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
